// File: rtl/ssd_scan_ctrl_pkg.sv
// ssd_scan_ctrl_pkg: shared seven-segment decode table and helper for the scanner
package ssd_scan_ctrl_pkg;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    return HEX_SEG[h];
  endfunction
endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// ssd_scan_ctrl_if: CPU-side display data in, scanned ssd pins and frame pulse out
interface ssd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 3
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    lz_blank;
  logic [BRIGHT_W-1:0]     brightness;
  logic                    blank;
  logic                    frame_start;
  logic [NUM_DIGITS+7:0]   ssd;
  modport master (output value, dp_mask, lz_blank, brightness, blank, input frame_start, ssd);
  modport slave  (input value, dp_mask, lz_blank, brightness, blank, output frame_start, ssd);
endinterface

// File: rtl/ssd_scan_ctrl_hex_decoder.sv
// ssd_scan_ctrl_hex_decoder: nibble to seven-segment pattern with output polarity applied
module ssd_scan_ctrl_hex_decoder
  import ssd_scan_ctrl_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb seg = hex_to_seg(nib) ^ {7{ACTIVE_LOW}};
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed hex display scanner with frame-latched data, LZ blanking and PWM
module ssd_scan_ctrl
  import ssd_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_W          = 16,
  parameter int BRIGHT_W       = 3,
  parameter bit AN_ACTIVE_LOW  = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic           sysclk,
  input logic           reset,
  ssd_scan_ctrl_if.slave bus
);
  localparam int DGW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic DP_OFF = SEG_ACTIVE_LOW;
  logic [DIV_W-1:0]        slot_cnt;
  logic [DGW-1:0]          digit;
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    sh_lz;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    hi_zero;
  logic                    slot_end;
  logic                    frame_end;
  logic                    lit;
  logic                    on;
  logic [3:0]              nib;
  logic [6:0]              seg_dec;
  logic [NUM_DIGITS+7:0]   ssd_nxt;
  logic [NUM_DIGITS+7:0]   ssd_q;
  logic                    fs_q;
  always_comb begin
    slot_end  = &slot_cnt;
    frame_end = slot_end && (digit == DGW'(NUM_DIGITS - 1));
  end
  // a digit is blanked only when it and every higher nibble are zero; digit 0 always shows
  always_comb begin
    hi_zero = 1'b1;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      hi_zero    = hi_zero & (sh_value[4*i +: 4] == 4'h0);
      lz_mask[i] = sh_lz & hi_zero;
    end
  end
  ssd_scan_ctrl_hex_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (.nib(nib), .seg(seg_dec));
  always_comb begin
    nib     = 4'(sh_value >> {digit, 2'b00});
    onehot  = NUM_DIGITS'(1) << digit;
    lit     = (&bus.brightness) | (slot_cnt[DIV_W-1 -: BRIGHT_W] < bus.brightness);
    on      = lit & ~bus.blank & ~lz_mask[digit];
    ssd_nxt = {(on ? onehot : '0) ^ AN_OFF, (on & sh_dp[digit]) ^ DP_OFF, on ? seg_dec : SEG_OFF};
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      slot_cnt <= '0;
      digit    <= '0;
      sh_value <= '0;
      sh_dp    <= '0;
      sh_lz    <= 1'b0;
      fs_q     <= 1'b0;
      ssd_q    <= {AN_OFF, DP_OFF, SEG_OFF};
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_end) digit <= frame_end ? '0 : digit + 1'b1;
      fs_q     <= frame_end;
      ssd_q    <= ssd_nxt;
      if (frame_end) begin
        sh_value <= bus.value;
        sh_dp    <= bus.dp_mask;
        sh_lz    <= bus.lz_blank;
      end
    end
  end
  assign bus.frame_start = fs_q;
  assign bus.ssd         = ssd_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed scan checks against a per-frame scoreboard of {frame_start, ssd}
module tb_ssd_scan_ctrl;
  typedef struct {
    string       tag;
    int          k;
    logic [12:0] exp;
  } ent_t;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  int   kcur = 0;
  ent_t sb[$];
  ssd_scan_ctrl_if #(.NUM_DIGITS(4), .BRIGHT_W(2)) bus ();
  ssd_scan_ctrl #(
    .NUM_DIGITS(4), .DIV_W(4), .BRIGHT_W(2), .AN_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .sysclk(clk),
    .reset (rst),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic expect_at(input string tag, input int k, input logic [12:0] exp);
    sb.push_back('{tag, k, exp});
  endtask
  // k counts falling edges since the last frame_start; output at k shows scan position k-1
  task automatic scan(input int kto);
    ent_t e;
    while (kcur < kto) begin
      @(negedge clk);
      kcur++;
      while (sb.size() != 0 && sb[0].k == kcur) begin
        e = sb.pop_front();
        chk(e.tag, {19'd0, bus.frame_start, bus.ssd}, {19'd0, e.exp});
      end
    end
  endtask
  task automatic wait_fs();
    for (int i = 0; i < 200 && !bus.frame_start; i++) @(negedge clk);
    chk("fs_wait", {31'd0, bus.frame_start}, 32'd1);
    kcur = 0;
  endtask
  initial begin
    rst = 1'b1;
    bus.value = 16'h12AF;
    bus.dp_mask = 4'b0000;
    bus.lz_blank = 1'b0;
    bus.brightness = 2'd3;
    bus.blank = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ssd", {20'd0, bus.ssd}, 32'h0FF);
    chk("rst_fs", {31'd0, bus.frame_start}, 32'd0);
    rst = 1'b0;
    kcur = 0;
    expect_at("zero_d0", 1, 13'h01C0);
    expect_at("zero_d1", 17, 13'h02C0);
    expect_at("zero_d3", 63, 13'h08C0);
    expect_at("first_fs", 64, 13'h18C0);
    scan(64);
    kcur = 0;
    expect_at("hex_F", 1, 13'h018E);
    expect_at("hex_F_end", 16, 13'h018E);
    expect_at("hex_A", 17, 13'h0288);
    expect_at("hex_2", 33, 13'h04A4);
    expect_at("hex_1", 49, 13'h08F9);
    scan(60);
    bus.value = 16'h0030;
    bus.lz_blank = 1'b1;
    bus.dp_mask = 4'b1111;
    wait_fs();
    expect_at("lz_d0", 1, 13'h0140);
    expect_at("lz_d1", 17, 13'h0230);
    expect_at("hold_d1", 21, 13'h0230);
    expect_at("lz_d2", 33, 13'h00FF);
    expect_at("lz_d3", 49, 13'h00FF);
    scan(20);
    bus.value = 16'h4567;
    scan(60);
    bus.lz_blank = 1'b0;
    bus.dp_mask = 4'b0000;
    wait_fs();
    expect_at("new_d0", 1, 13'h01F8);
    expect_at("new_d1", 17, 13'h0282);
    expect_at("new_d3", 49, 13'h0899);
    scan(60);
    bus.brightness = 2'd1;
    wait_fs();
    expect_at("b1_s0", 1, 13'h01F8);
    expect_at("b1_s3", 4, 13'h01F8);
    expect_at("b1_s4", 5, 13'h00FF);
    expect_at("b1_s15", 16, 13'h00FF);
    expect_at("b1_d1s0", 17, 13'h0282);
    expect_at("b0_live", 21, 13'h00FF);
    expect_at("b0_d2", 33, 13'h00FF);
    expect_at("b0_d3", 49, 13'h00FF);
    scan(20);
    bus.brightness = 2'd0;
    scan(60);
    wait_fs();
    expect_at("b0_f_d0", 1, 13'h00FF);
    expect_at("b0_f_d1", 17, 13'h00FF);
    expect_at("b0_f_d2", 33, 13'h00FF);
    expect_at("b0_f_d3", 49, 13'h00FF);
    scan(60);
    bus.brightness = 2'd3;
    wait_fs();
    expect_at("pre_blank", 35, 13'h0492);
    scan(35);
    bus.blank = 1'b1;
    expect_at("blank", 36, 13'h00FF);
    scan(36);
    bus.blank = 1'b0;
    expect_at("unblank", 37, 13'h0492);
    scan(37);
    rst = 1'b1;
    expect_at("mid_rst", 38, 13'h00FF);
    scan(38);
    @(negedge clk);
    rst = 1'b0;
    kcur = 0;
    expect_at("rst_d0", 1, 13'h01C0);
    expect_at("rst_d1", 17, 13'h02C0);
    expect_at("rst_no_fs", 63, 13'h08C0);
    expect_at("rst_fs", 64, 13'h18C0);
    scan(64);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
